// File: rtl/pe_accum_stream_if.sv
// Stream bundle for pe_accum_stream: partial-sum input and AXI4-Stream pixel output.
interface pe_accum_stream_if #(
  parameter int PSUM_WIDTH = 48,
  parameter int OUT_WIDTH  = 16
);
  logic [PSUM_WIDTH-1:0] s_psum_tdata;
  logic                  s_psum_tvalid;
  logic                  s_psum_tready;
  logic [OUT_WIDTH-1:0]  m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  // Both streams: a beat moves on a rising edge with valid && ready high; a producer
  // keeps data/last stable while valid is high and ready is low, and never drops valid.
  modport slave (
    input  s_psum_tdata, s_psum_tvalid, m_axis_tready,
    output s_psum_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport master (
    output s_psum_tdata, s_psum_tvalid, m_axis_tready,
    input  s_psum_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/pe_accum_stream.sv
// Accumulates channel-major partial sums per pixel, then adds bias, activates, shifts,
// saturates and streams one output pixel per final-channel psum.
module pe_accum_stream #(
  parameter int PSUM_WIDTH = 48,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int CH_WIDTH   = 8,
  parameter int ACT_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [CH_WIDTH-1:0]         num_channels,
  input  logic [ADDR_WIDTH:0]         frame_len,
  input  logic signed [ACC_WIDTH-1:0] bias,
  pe_accum_stream_if.slave            bus,
  output logic                        idle,
  output logic                        frame_done,
  output logic [ADDR_WIDTH-1:0]       pixel_addr,
  output logic [1:0]                  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FINAL = 2'd2, FLUSH = 2'd3} state_e;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         pix_q, pix_d;
  logic [CH_WIDTH-1:0]           ch_q, ch_d;
  logic [CH_WIDTH-1:0]           nch_q, nch_d;
  logic [ADDR_WIDTH:0]           len_q, len_d;
  logic signed [ACC_WIDTH-1:0]   bias_q, bias_d;
  logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          done_q, done_d;

  logic [ACC_WIDTH-1:0]          acc_mem [2**ADDR_WIDTH];
  logic                          acc_we;

  logic signed [PSUM_WIDTH-1:0]  psum_s;
  logic signed [ACC_WIDTH-1:0]   psum_ext, acc_rd, acc_term, sum_base;
  logic signed [ACC_WIDTH-1:0]   v_sum, v_act, v_shift;
  logic [OUT_WIDTH-1:0]          v_sat;
  logic [CH_WIDTH-1:0]           ch_next;
  logic                          s_ready, s_hs, m_hs, last_pix;

  assign psum_s   = bus.s_psum_tdata;
  assign psum_ext = ACC_WIDTH'(psum_s);
  assign acc_rd   = acc_mem[pix_q];
  // Channel 0 overwrites the buffer, so stale contents from a previous frame never leak in.
  assign acc_term = (ch_q == '0) ? '0 : acc_rd;
  assign sum_base = acc_term + psum_ext;
  assign ch_next  = ch_q + CH_WIDTH'(1);
  assign last_pix = ({1'b0, pix_q} == (len_q - (ADDR_WIDTH + 1)'(1)));

  always_comb begin
    v_sum = sum_base + bias_q;
    v_act = v_sum;
    if (v_sum[ACC_WIDTH-1]) begin
      if (ACT_MODE == 1)      v_act = '0;
      else if (ACT_MODE == 2) v_act = v_sum >>> 3;
    end
    v_shift = v_act >>> SHIFT;
    if (v_shift > OUT_MAX)      v_sat = OUT_MAX[OUT_WIDTH-1:0];
    else if (v_shift < OUT_MIN) v_sat = OUT_MIN[OUT_WIDTH-1:0];
    else                        v_sat = v_shift[OUT_WIDTH-1:0];
  end

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ACCUM:   s_ready = 1'b1;
      FINAL:   s_ready = !out_valid_q || bus.m_axis_tready;
      default: s_ready = 1'b0;
    endcase
  end

  assign s_hs = bus.s_psum_tvalid && s_ready;
  assign m_hs = out_valid_q && bus.m_axis_tready;

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    ch_d        = ch_q;
    nch_d       = nch_q;
    len_d       = len_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    acc_we      = 1'b0;
    if (m_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          nch_d   = (num_channels == '0) ? CH_WIDTH'(1) : num_channels;
          len_d   = frame_len;
          bias_d  = bias;
          pix_d   = '0;
          ch_d    = '0;
          state_d = (num_channels > CH_WIDTH'(1)) ? ACCUM : FINAL;
        end
      end
      ACCUM: begin
        if (s_hs) begin
          acc_we = 1'b1;
          if (last_pix) begin
            pix_d = '0;
            ch_d  = ch_next;
            if (ch_next == (nch_q - CH_WIDTH'(1))) state_d = FINAL;
          end else begin
            pix_d = pix_q + ADDR_WIDTH'(1);
          end
        end
      end
      FINAL: begin
        if (s_hs) begin
          out_data_d  = v_sat;
          out_valid_d = 1'b1;
          out_last_d  = last_pix;
          if (last_pix) begin
            pix_d   = '0;
            state_d = FLUSH;
          end else begin
            pix_d = pix_q + ADDR_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (m_hs && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      ch_q        <= '0;
      nch_q       <= '0;
      len_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      nch_q       <= nch_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_we) acc_mem[pix_q] <= sum_base;
  end

  assign bus.s_psum_tready = s_ready;
  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tvalid = out_valid_q;
  assign bus.m_axis_tlast  = out_last_q;
  assign idle              = (state_q == IDLE);
  assign frame_done        = done_q;
  assign pixel_addr        = pix_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_pe_accum_stream.sv
// Bench for pe_accum_stream: four instances (SHIFT=8 plain, SHIFT=0 with ACT_MODE 0/1/2)
// share stimulus; a start select picks which one runs each frame.
module tb_pe_accum_stream;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  logic [1:0] sel;
  logic drv_start;
  logic [7:0] drv_nch;
  logic [AW:0] drv_len;
  logic signed [47:0] drv_bias;
  logic [47:0] drv_tdata;
  logic drv_tvalid;
  logic drv_tready;

  logic [15:0]   o_tdata  [4];
  logic          o_tvalid [4];
  logic          o_tlast  [4];
  logic          o_sready [4];
  logic          o_idle   [4];
  logic          o_done   [4];
  logic [AW-1:0] o_paddr  [4];
  logic [1:0]    o_state  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pe_accum_stream_if #(.PSUM_WIDTH(48), .OUT_WIDTH(16)) bus ();
    assign bus.s_psum_tdata  = drv_tdata;
    assign bus.s_psum_tvalid = drv_tvalid;
    assign bus.m_axis_tready = drv_tready;
    assign o_tdata[g]  = bus.m_axis_tdata;
    assign o_tvalid[g] = bus.m_axis_tvalid;
    assign o_tlast[g]  = bus.m_axis_tlast;
    assign o_sready[g] = bus.s_psum_tready;
    pe_accum_stream #(
      .PSUM_WIDTH(48), .ACC_WIDTH(48), .OUT_WIDTH(16),
      .SHIFT((g == 0) ? 8 : 0), .ADDR_WIDTH(AW), .CH_WIDTH(8),
      .ACT_MODE((g == 0) ? 0 : g - 1)
    ) u_dut (
      .clk(clk), .Reset(rst_n), .start(drv_start && (sel == 2'(g))),
      .num_channels(drv_nch), .frame_len(drv_len), .bias(drv_bias),
      .bus(bus.slave), .idle(o_idle[g]), .frame_done(o_done[g]),
      .pixel_addr(o_paddr[g]), .dbg_state(o_state[g])
    );
  end

  wire [15:0]   cur_tdata  = o_tdata[sel];
  wire          cur_tvalid = o_tvalid[sel];
  wire          cur_tlast  = o_tlast[sel];
  wire          cur_sready = o_sready[sel];
  wire          cur_idle   = o_idle[sel];
  wire          cur_done   = o_done[sel];
  wire [AW-1:0] cur_paddr  = o_paddr[sel];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail = 0;
  longint psum_q[$];
  logic [15:0] exp_q[$];

  typedef struct {
    int          s;
    longint      psum;
    longint      bias;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic longint rnd20();
    return longint'($urandom_range(0, 2097152)) - 64'sd1048576;
  endfunction

  // Reference: wrap to 48 bits, activate, arithmetic shift, clamp to 16-bit signed.
  function automatic logic [15:0] model_pix(input longint total, input int s);
    longint v;
    int mode;
    int shift;
    mode  = (s == 0) ? 0 : s - 1;
    shift = (s == 0) ? 8 : 0;
    v = (total <<< 16) >>> 16;
    if (v < 0 && mode == 1) v = 0;
    else if (v < 0 && mode == 2) v = v >>> 3;
    v = v >>> shift;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic check_reset_all();
    for (int g = 0; g < 4; g++) begin
      check("rst_idle", 64'(o_idle[g]), 64'd1);
      check("rst_tvalid", 64'(o_tvalid[g]), 64'd0);
      check("rst_tlast", 64'(o_tlast[g]), 64'd0);
      check("rst_tdata", 64'(o_tdata[g]), 64'd0);
      check("rst_sready", 64'(o_sready[g]), 64'd0);
      check("rst_done", 64'(o_done[g]), 64'd0);
      check("rst_paddr", 64'(o_paddr[g]), 64'd0);
    end
  endtask

  // driver + scoreboard for one frame; psum_q/exp_q are preloaded by the caller
  task automatic run_frame(input int nch, input int len, input longint bias,
                           input int vpct, input int rpct, input int stall_at,
                           input int poke_at, input int rst_at);
    int idx, beats, cyc, stall_left, pulses, last_at, total, acc_beats, eff;
    logic held_v, held_last;
    logic [15:0] held, e;
    eff = (nch == 0) ? 1 : nch;
    total = psum_q.size();
    acc_beats = (eff - 1) * len;
    idx = 0; beats = 0; cyc = 0; stall_left = 0; pulses = 0; last_at = -1;
    held_v = 1'b0; held_last = 1'b0; held = '0;
    @(negedge clk);
    drv_start = 1'b1; drv_nch = 8'(nch); drv_len = (AW + 1)'(len);
    drv_bias = 48'(bias); drv_tvalid = 1'b0;
    while (cyc < 2000 && !(last_at >= 0 && cyc >= last_at + 4)) begin
      @(negedge clk);
      cyc++;
      drv_start = 1'b0;
      if (cur_done) pulses++;
      if (last_at >= 0 && cyc == last_at + 1) begin
        check("done_after_last", 64'(cur_done), 64'd1);
        check("idle_after_last", 64'(cur_idle), 64'd1);
      end
      if (held_v) begin
        check("hold_tvalid", 64'(cur_tvalid), 64'd1);
        check("hold_tdata", 64'(cur_tdata), 64'(held));
        check("hold_tlast", 64'(cur_tlast), 64'(held_last));
      end
      if (rst_at >= 0 && beats == rst_at) begin
        check("busy_before_rst", 64'(cur_idle), 64'd0);
        rst_n = 1'b0;
        drv_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_tvalid", 64'(cur_tvalid), 64'd0);
        check("midrst_idle", 64'(cur_idle), 64'd1);
        check("midrst_sready", 64'(cur_sready), 64'd0);
        check("midrst_paddr", 64'(cur_paddr), 64'd0);
        check("midrst_done", 64'(cur_done), 64'd0);
        psum_q.delete();
        exp_q.delete();
        return;
      end
      if (cyc == poke_at) begin
        drv_start = 1'b1; drv_nch = 8'd1; drv_len = (AW + 1)'(1);
      end
      if (idx < total) begin
        drv_tvalid = ($urandom_range(1, 100) <= vpct);
        drv_tdata  = drv_tvalid ? 48'(psum_q[idx]) : 48'({$urandom, $urandom});
      end else begin
        drv_tvalid = 1'b0;
      end
      if (stall_left > 0) begin
        drv_tready = 1'b0;
        stall_left--;
      end else if (stall_at >= 0 && beats == stall_at && cur_tvalid) begin
        drv_tready = 1'b0;
        stall_left = 4;
        stall_at = -1;
      end else begin
        drv_tready = ($urandom_range(1, 100) <= rpct);
      end
      #1;
      if (idx < acc_beats) check("accum_ready", 64'(cur_sready), 64'd1);
      if (cur_tvalid && !drv_tready) check("bp_ready_low", 64'(cur_sready), 64'd0);
      held_v = cur_tvalid && !drv_tready;
      held = cur_tdata;
      held_last = cur_tlast;
      if (drv_tvalid && cur_sready) idx++;
      if (cur_tvalid && drv_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got beat tdata %0d, required no beat", cur_tdata);
        end else begin
          e = exp_q.pop_front();
          check("tdata", 64'(cur_tdata), 64'(e));
          check("tlast", 64'(cur_tlast), (exp_q.size() == 0) ? 64'd1 : 64'd0);
          beats++;
          if (exp_q.size() == 0) last_at = cyc;
        end
      end
    end
    if (last_at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: state %0d beats %0d, required frame completion",
               o_state[sel], beats);
    end
    check("psums_consumed", idx, total);
    check("exp_drained", exp_q.size(), 0);
    check("done_pulses", pulses, 1);
    psum_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_frame(input int s, input int nch, input int len, input int vpct,
                            input int rpct, input int stall_at, input int poke_at,
                            input int rst_at);
    longint tot[16];
    longint b, p;
    int eff;
    eff = (nch == 0) ? 1 : nch;
    b = rnd20();
    for (int i = 0; i < 16; i++) tot[i] = 0;
    for (int c = 0; c < eff; c++) begin
      for (int i = 0; i < len; i++) begin
        p = rnd20();
        psum_q.push_back(p);
        tot[i] += p;
      end
    end
    for (int i = 0; i < len; i++) exp_q.push_back(model_pix(tot[i] + b, s));
    sel = 2'(s);
    run_frame(nch, len, b, vpct, rpct, stall_at, poke_at, rst_at);
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'd0; drv_start = 1'b0; drv_nch = 8'd1; drv_len = '0;
    drv_bias = '0; drv_tdata = '0; drv_tvalid = 1'b0; drv_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_all();
    rst_n = 1'b1;

    // single channel, SHIFT=8
    sel = 2'd0;
    psum_q = '{0, 256, -512, 65280};
    exp_q  = '{16'd1, 16'd2, 16'hFFFF, 16'd256};
    run_frame(1, 4, 256, 80, 80, -1, -1, -1);

    // three-channel accumulation at full rate, SHIFT=0
    sel = 2'd1;
    psum_q = '{100, 100, 100, 100, 100, 100};
    exp_q  = '{16'd300, 16'd300};
    run_frame(3, 2, 0, 100, 100, -1, -1, -1);

    // saturation / activation / shift table, one-pixel frames
    vecs[0]  = '{1, 40000, 0, 16'(32767)};
    vecs[1]  = '{1, -40000, 0, 16'(-32768)};
    vecs[2]  = '{2, -40000, 0, 16'(0)};
    vecs[3]  = '{3, -40000, 0, 16'(-5000)};
    vecs[4]  = '{3, 40000, 0, 16'(32767)};
    vecs[5]  = '{2, 1234, 0, 16'(1234)};
    vecs[6]  = '{1, 32767, 0, 16'(32767)};
    vecs[7]  = '{1, 32768, 0, 16'(32767)};
    vecs[8]  = '{1, -32768, 0, 16'(-32768)};
    vecs[9]  = '{1, -32769, 0, 16'(-32768)};
    vecs[10] = '{3, -7, 0, 16'(-1)};
    vecs[11] = '{1, 30000, 5000, 16'(32767)};
    vecs[12] = '{0, 255, 0, 16'(0)};
    vecs[13] = '{0, -1, 0, 16'(-1)};
    vecs[14] = '{0, -300, 44, 16'(-1)};
    vecs[15] = '{3, -40000, 8000, 16'(-4000)};
    vecs[16] = '{1, 64'sd140737488355327, 1, 16'(-32768)};
    for (int i = 0; i < 17; i++) begin
      sel = 2'(vecs[i].s);
      psum_q.push_back(vecs[i].psum);
      exp_q.push_back(vecs[i].exp);
      run_frame(1, 1, vecs[i].bias, 100, 100, -1, -1, -1);
    end

    // output backpressure: ready low for 5 cycles after 3 beats
    rand_frame(0, 2, 8, 100, 100, 3, -1, -1);

    // start with frame_len = 0 is ignored
    sel = 2'd0;
    @(negedge clk);
    drv_start = 1'b1; drv_nch = 8'd2; drv_len = '0;
    @(negedge clk);
    drv_start = 1'b0;
    check("len0_idle", 64'(cur_idle), 64'd1);
    check("len0_sready", 64'(cur_sready), 64'd0);
    @(negedge clk);
    check("len0_idle_hold", 64'(cur_idle), 64'd1);

    // start pulsed during ACCUM is ignored
    rand_frame(1, 4, 8, 100, 90, -1, 5, -1);

    // reset during FINAL, then a clean frame
    rand_frame(0, 1, 8, 100, 100, -1, -1, 2);
    rand_frame(0, 2, 5, 90, 90, -1, -1, -1);

    // boundaries: full buffer depth, num_channels = 0
    rand_frame(0, 2, 16, 85, 75, -1, -1, -1);
    rand_frame(2, 0, 3, 85, 75, -1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      rand_frame($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 16),
                 $urandom_range(50, 100), $urandom_range(40, 100), -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_accum_stream.md
PE_ACCUM_STREAM -- requirements
Module: pe_accum_stream

Interface
REQ-001 SHALL have parameter PSUM_WIDTH, default 48, meaning width of the signed partial sum from the PE datapath.
REQ-002 SHALL have parameter ACC_WIDTH, default 48, meaning width of the signed accumulator and bias.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, meaning width of the signed output pixel.
REQ-004 SHALL have parameter SHIFT, default 8, meaning arithmetic right shift applied before saturation.
REQ-005 SHALL have parameter ADDR_WIDTH, default 14, meaning accumulator buffer depth of 2^ADDR_WIDTH pixels.
REQ-006 SHALL have parameter CH_WIDTH, default 8, meaning width of the input-channel count.
REQ-007 SHALL have parameter ACT_MODE, default 0, meaning activation: 0 none, 1 ReLU, 2 leaky (negative values >>> 3).
REQ-008 SHALL have the port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-009 SHALL have the port Reset, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have the port start, input, 1 bit: a single-cycle pulse that begins a frame.
REQ-011 SHALL have the port num_channels, input, CH_WIDTH bits: the input-channel count, latched on start.
REQ-012 SHALL have the port frame_len, input, ADDR_WIDTH+1 bits: pixels per frame (1..2^ADDR_WIDTH), latched on start.
REQ-013 SHALL have the port bias, input, ACC_WIDTH bits, signed: the per-frame bias, latched on start.
REQ-014 SHALL have the ports s_psum_tdata (input, PSUM_WIDTH bits), s_psum_tvalid (input, 1 bit) and s_psum_tready (output, 1 bit): the partial-sum input stream, ordered channel-major and pixel-minor.
REQ-015 SHALL have the ports m_axis_tdata (output, OUT_WIDTH bits), m_axis_tvalid (output, 1 bit), m_axis_tlast (output, 1 bit) and m_axis_tready (input, 1 bit): the AXI4-Stream output.
REQ-016 SHALL have the outputs idle, frame_done and pixel_addr (1, 1 and ADDR_WIDTH bits respectively): status, and the current buffer address for the noise/bias address counters.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM, FINAL and FLUSH.
REQ-018 SHALL, in IDLE, when start is high and frame_len is non-zero, latch the parameters, clear the pixel and channel counters, and go to ACCUM if the latched num_channels > 1, otherwise to FINAL.
REQ-019 SHALL treat num_channels = 0 as 1, and SHALL ignore start when frame_len = 0 or when the FSM is not in IDLE.
REQ-020 SHALL define a handshake as a cycle with s_psum_tvalid and s_psum_tready both high; each handshake consumes one psum at address pixel_addr, and pixel_addr increments by 1 per handshake.
REQ-021 SHALL, in ACCUM, for channel 0 write psum (sign-extended) to acc[pixel_addr], and for later channels write acc[pixel_addr] + psum, with the addition wrapping modulo 2^ACC_WIDTH.
REQ-022 SHALL hold s_psum_tready high in ACCUM, sustaining 1 handshake per cycle with no bubbles, including at channel boundaries.
REQ-023 SHALL, on the handshake at pixel_addr = frame_len-1, reset pixel_addr to 0, increment the channel counter, and enter FINAL when the new channel index equals num_channels-1.
REQ-024 SHALL, in FINAL, compute v = acc[pixel_addr] + psum + bias at ACC_WIDTH (acc term 0 when num_channels = 1), apply ACT_MODE, apply >>> SHIFT, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-025 SHALL, in FINAL, drive s_psum_tready = !m_axis_tvalid || m_axis_tready, using a one-entry output register.
REQ-026 SHALL register a handshake's result in the output register at the next edge, so that m_axis_tvalid rises 1 cycle after the handshake.
REQ-027 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-028 SHALL assert m_axis_tlast with the output of pixel frame_len-1 only.
REQ-029 SHALL go to FLUSH after the final FINAL handshake, then go to IDLE and pulse frame_done for 1 cycle on the m_axis handshake of the tlast beat.
REQ-030 SHALL drive idle high exactly in IDLE, and SHALL drive s_psum_tready low in IDLE and FLUSH.
REQ-031 SHALL leave acc contents unspecified at the start of a frame, since channel 0 overwrites them.

Reset
REQ-032 SHALL, while Reset = 0 at a clock edge, enter IDLE, zero all counters and pixel_addr, and drive s_psum_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata and frame_done to 0 and idle to 1.
REQ-033 SHALL, when reset mid-frame, abandon the frame with no further output beats; acc contents SHALL be don't-care.

Verification
REQ-034 SHALL verify the single-channel case: num_channels=1, frame_len=4, bias=256, SHIFT=8, psums 0, 256, -512, 65280 -> outputs 1, 2, -1, 256; tlast on beat 4; frame_done pulses once.
REQ-035 SHALL verify channel accumulation: num_channels=3, frame_len=2, psum 100 per pixel per channel, bias=0, SHIFT=0 -> outputs 300, 300; s_psum_tready high continuously through the ACCUM phase.
REQ-036 SHALL verify saturation and activation: SHIFT=0, OUT_WIDTH=16, v=40000 -> 32767; v=-40000 -> -32768 (ACT_MODE 0), 0 (ACT_MODE 1), -5000 (ACT_MODE 2).
REQ-037 SHALL verify backpressure: m_axis_tready held low for 5 cycles mid-frame -> tdata stable, s_psum_tready low, no beats lost or duplicated.
REQ-038 SHALL verify ignored starts: start pulsed during ACCUM has no effect, and start with frame_len=0 leaves idle=1.
REQ-039 SHALL verify mid-frame reset: Reset low for 1 cycle during FINAL -> m_axis_tvalid=0 next cycle, idle=1, and a new frame afterwards runs correctly.
